// File: rtl/vga_tape_renderer_if.sv
// Tape memory read port between the VGA renderer and the cpu_core data memory.
// The renderer drives the cell address every pixel clock and gets back the
// cell byte a fixed number of clocks later; there is no handshake.
interface vga_tape_renderer_if;
  logic [13:0] cell_addr;
  logic [7:0]  cell_data;

  // Renderer side: issues addresses, consumes returned bytes.
  modport master (output cell_addr, input cell_data);
  // Memory side: sees addresses, returns bytes MEM_LAT clocks later.
  modport slave  (input cell_addr, output cell_data);
endinterface

// File: rtl/vga_tape_renderer.sv
// Pixel pipeline between the sync generator and the VGA pins.
// Pixel counters become a tape-cell read address. The returned byte becomes a
// 4:4:4 colour, with an optional 1-px cell grid and a blinking cursor on the
// cell that the data pointer selects. Syncs travel alongside the colour so
// both leave on the same edge, MEM_LAT+2 clocks after the counters arrive.
module vga_tape_renderer #(
  parameter int   MEM_LAT   = 1,    // cell_data latency after cell_addr, 1..3
  parameter int   BLINK_BIT = 4,    // frame_cnt bit that sets the blink phase
  parameter logic SYNC_IDLE = 1'b1  // inactive sync level held during reset
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [9:0]                 counter_x,
  input  logic [9:0]                 counter_y,
  input  logic                       in_display,
  input  logic                       h_sync_in,
  input  logic                       v_sync_in,
  vga_tape_renderer_if.master        mem,
  input  logic [13:0]                data_ptr,
  input  logic                       grid_en,
  output logic                       vga_h_sync,
  output logic                       vga_v_sync,
  output logic [3:0]                 r,
  output logic [3:0]                 g,
  output logic [3:0]                 b,
  output logic                       frame_start
);

  // Everything a pixel needs to carry while its cell byte is being fetched.
  typedef struct packed {
    logic [13:0] addr;
    logic [2:0]  x_lo;
    logic [2:0]  y_lo;
    logic        disp;
    logic        hs;
    logic        vs;
  } side_t;

  // Idle pixel: blanked, syncs inactive, so a refilling pipeline shows nothing.
  localparam side_t SIDE_IDLE = '{addr: '0, x_lo: '0, y_lo: '0, disp: 1'b0,
                                  hs: SYNC_IDLE, vs: SYNC_IDLE};

  side_t       s0;
  side_t       dly [MEM_LAT];
  side_t       tail;
  logic [7:0]  frame_cnt;
  logic [13:0] ptr_latch;
  logic        at_origin;
  logic        cursor_hit;
  logic        border_px;
  logic        grid_px;

  assign at_origin     = (counter_x == 10'd0) && (counter_y == 10'd0);
  assign mem.cell_addr = s0.addr;
  assign tail          = dly[MEM_LAT-1];

  // Stage 0: form the cell address and capture the pixel's side signals.
  // NOTE: state is updated with <= so every stage samples its predecessor's
  // value from before the edge; blocking = here would collapse the pipeline.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s0 <= SIDE_IDLE;
    end else begin
      s0 <= '{addr: {counter_y[9:3], counter_x[9:3]},
              x_lo: counter_x[2:0], y_lo: counter_y[2:0],
              disp: in_display, hs: h_sync_in, vs: v_sync_in};
    end
  end

  // Delay line matching the memory read latency.
  // NOTE: this small register array is reset on purpose: stale entries would
  // otherwise leak visible pixels and sync edges right after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MEM_LAT; i++) dly[i] <= SIDE_IDLE;
    end else begin
      dly[0] <= s0;
      for (int i = 1; i < MEM_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  // Frame bookkeeping: pulse, blink counter and cursor snapshot at (0,0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      ptr_latch   <= '0;
    end else begin
      frame_start <= at_origin;
      if (at_origin) begin
        frame_cnt <= frame_cnt + 8'd1;
        ptr_latch <= data_ptr;
      end
    end
  end

  // Cursor uses only the per-frame snapshot so it never tears mid-frame.
  assign cursor_hit = (tail.addr == ptr_latch) && frame_cnt[BLINK_BIT];
  assign border_px  = (tail.x_lo == 3'd0) || (tail.x_lo == 3'd7) ||
                      (tail.y_lo == 3'd0) || (tail.y_lo == 3'd7);
  assign grid_px    = (tail.x_lo == 3'd0) || (tail.y_lo == 3'd0);

  // Colour stage: priority select of the output colour, syncs re-aligned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r          <= '0;
      g          <= '0;
      b          <= '0;
      vga_h_sync <= SYNC_IDLE;
      vga_v_sync <= SYNC_IDLE;
    end else begin
      vga_h_sync <= tail.hs;
      vga_v_sync <= tail.vs;
      if (!tail.disp) begin
        r <= 4'h0; g <= 4'h0; b <= 4'h0;
      end else if (cursor_hit && border_px) begin
        r <= 4'hF; g <= 4'hF; b <= 4'hF;
      end else if (grid_en && grid_px) begin
        r <= 4'h2; g <= 4'h2; b <= 4'h2;
      end else begin
        r <= mem.cell_data[7:4];
        g <= mem.cell_data[3:0];
        b <= 4'h0;
      end
    end
  end

endmodule
